stream_mux_rr: RTL

//  N-input, WIDTH-bit packet-stream multiplexer with valid/ready handshake and a registered

---
 rtl/stream_mux_rr_pkg.sv | 11 +
 rtl/stream_mux_rr_if.sv | 34 +++
 rtl/stream_mux_rr_arbiter.sv | 38 +++
 rtl/stream_mux_rr.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/stream_mux_rr_pkg.sv
// Shared types and width helper for the round-robin packet-stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {IDLE, LOCKED} mux_state_e;

    // A single channel still needs a 1-bit select/source field.
    function automatic int sel_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Bundle of the N input streams, the output stream and the selection controls.
interface stream_mux_rr_if
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SELW = sel_w(N);

    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_last;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_last;
    logic [SELW-1:0]      out_src;
    logic                 out_valid;
    logic                 out_ready;

    // The multiplexer itself.
    modport slave (
        input  mode, sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_last, out_src, out_valid
    );

    // Producers, consumer and control logic around the multiplexer.
    modport master (
        output mode, sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_last, out_src, out_valid
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by ptr, pick the lowest, rotate back.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = sel_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx
);

    logic [N-1:0]    rot;
    logic [SELW-1:0] k;
    logic            found;
    logic [SELW:0]   sum;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        k     = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                k     = SELW'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, k};
        if (sum >= (SELW+1)'(N)) begin
            sum = sum - (SELW+1)'(N);
        end
        gnt_idx = sum[SELW-1:0];
        gnt     = found ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input packet-stream mux: round-robin or fixed select, packet lock, registered output.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = sel_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    stream_mux_rr_if.slave  bus
);

    mux_state_e      state_q, state_d;
    logic [SELW-1:0] lk_q, lk_d;
    logic            lk_mode_q, lk_mode_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [SELW-1:0]  out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;

    logic [N-1:0]     rr_gnt;
    logic [SELW-1:0]  rr_idx;
    logic [N-1:0]     gnt;
    logic [SELW-1:0]  gnt_idx;
    logic [N-1:0]     in_ready_c;
    logic             load_en;
    logic             accept;
    logic             acc_last;
    logic             mode_eff;
    logic [WIDTH-1:0] data_sel;

    rr_arbiter #(.N(N)) u_arb (
        .req     (bus.in_valid),
        .ptr     (rr_ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    assign load_en = !out_valid_q || bus.out_ready;

    // Grant and ready decode; a locked packet owns the mux whatever mode, sel or other valids do.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        unique case (state_q)
            LOCKED: begin
                gnt     = N'(1) << lk_q;
                gnt_idx = lk_q;
            end
            default: begin
                if (bus.mode) begin
                    gnt     = (N'(1) << bus.sel) & bus.in_valid;
                    gnt_idx = bus.sel;
                end else begin
                    gnt     = rr_gnt;
                    gnt_idx = rr_idx;
                end
            end
        endcase
        in_ready_c = load_en ? gnt : '0;
    end

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                data_sel = data_sel | bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept   = |(in_ready_c & bus.in_valid);
    assign acc_last = |(gnt & bus.in_last);
    assign mode_eff = (state_q == LOCKED) ? lk_mode_q : bus.mode;

    // Packet FSM: a packet boundary moves rr_ptr only for arbitrated packets.
    always_comb begin
        state_d   = state_q;
        lk_d      = lk_q;
        lk_mode_d = lk_mode_q;
        rr_ptr_d  = rr_ptr_q;
        if (accept) begin
            if (acc_last) begin
                state_d = IDLE;
                if (!mode_eff) begin
                    rr_ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + SELW'(1);
                end
            end else begin
                state_d   = LOCKED;
                lk_d      = gnt_idx;
                lk_mode_d = mode_eff;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (load_en) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d = data_sel;
                out_last_d = acc_last;
                out_src_d  = gnt_idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lk_q      <= '0;
            lk_mode_q <= 1'b0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            lk_q      <= lk_d;
            lk_mode_q <= lk_mode_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;

endmodule
